// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read program ROM.
// Optional macro IFETCH_REL_BRANCH_EN makes branch_target a signed PC-relative offset.
module instr_fetch #(
    parameter int PC_W     = 5,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               halt_req,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    logic [PC_W-1:0] w_target;
    logic            w_redirect;

`ifdef IFETCH_REL_BRANCH_EN
    // Offset is two's complement; plain modulo-2^PC_W addition handles the sign.
    assign w_target = r_pc + branch_target;
`else
    assign w_target = branch_target;
`endif

    assign w_redirect = branch_taken && (r_state == S_RUN) && !stall;

    // While reset is held the ROM is primed with RESET_PC so S_FILL sees it.
    always_comb begin
        imem_addr = r_fetch_pc;
        imem_en   = (r_state != S_HALT) && !stall;
        if (reset) begin
            imem_addr = PC_RST;
            imem_en   = 1'b1;
        end else if (w_redirect) begin
            imem_addr = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FILL;
            r_fetch_pc <= PC_RST;
            r_pc       <= PC_RST;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_pc       <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + PC_W'(1);
                    r_valid    <= 1'b1;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    if (!stall) begin
                        // Halt outranks a simultaneous branch.
                        if (halt_req) begin
                            r_valid <= 1'b0;
                            r_state <= S_HALT;
                        end else if (branch_taken) begin
                            r_pc       <= w_target;
                            r_fetch_pc <= w_target + PC_W'(1);
                        end else begin
                            r_pc       <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + PC_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_FILL;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = imem_data;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 16;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               halt_req;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc_out;

    logic [INSTR_W-1:0] rom [32];
    int checks;
    int failures;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt_req     (halt_req),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
    end

    function automatic logic [INSTR_W-1:0] romval(input int i);
        return 16'hA000 + INSTR_W'(i) * 16'h0103;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        halt_req = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({instr_valid, pc_out, imem_en, imem_addr} !== {1'b0, 5'd0, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL reset_fill: valid/pc/en/addr=%b/%0d/%b/%0d want 0/0/1/0",
                     instr_valid, pc_out, imem_en, imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({instr_valid, pc_out, instr} !== {1'b1, PC_W'(k), romval(k)}) begin
                failures++;
                $display("FAIL reset_seq%0d: valid/pc/instr=%b/%0d/%h want 1/%0d/%h",
                         k, instr_valid, pc_out, instr, k, romval(k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_en: imem_en=%b want 0", imem_en);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({instr_valid, pc_out, instr, imem_en} !== {1'b1, 5'd1, romval(1), 1'b0}) begin
                failures++;
                $display("FAIL stall_hold%0d: valid/pc/instr/en=%b/%0d/%h/%b want 1/1/%h/0",
                         k, instr_valid, pc_out, instr, imem_en, romval(1));
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 5'd2, romval(2)}) begin
            failures++;
            $display("FAIL stall_release: valid/pc/instr=%b/%0d/%h want 1/2/%h",
                     instr_valid, pc_out, instr, romval(2));
        end
    endtask

    task automatic test_branch();
        int tgt;
        // Continues from pc_out=2 left by test_stall.
`ifdef IFETCH_REL_BRANCH_EN
        tgt = 0;
        branch_target = 5'h1E;
`else
        tgt = 9;
        branch_target = 5'd9;
`endif
        branch_taken = 1'b1;
        #1;
        checks++;
        if (imem_addr !== PC_W'(tgt)) begin
            failures++;
            $display("FAIL branch_addr: imem_addr=%0d want %0d", imem_addr, tgt);
        end
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, PC_W'(tgt), romval(tgt)}) begin
            failures++;
            $display("FAIL branch_target: valid/pc/instr=%b/%0d/%h want 1/%0d/%h",
                     instr_valid, pc_out, instr, tgt, romval(tgt));
        end
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, PC_W'(tgt + 1), romval(tgt + 1)}) begin
            failures++;
            $display("FAIL branch_next: valid/pc/instr=%b/%0d/%h want 1/%0d/%h",
                     instr_valid, pc_out, instr, tgt + 1, romval(tgt + 1));
        end
    endtask

    task automatic test_self_loop();
        int p;
        p = int'(pc_out);
`ifdef IFETCH_REL_BRANCH_EN
        branch_target = 5'd0;
`else
        branch_target = PC_W'(p);
`endif
        branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({instr_valid, pc_out, instr} !== {1'b1, PC_W'(p), romval(p)}) begin
                failures++;
                $display("FAIL self_loop%0d: valid/pc/instr=%b/%0d/%h want 1/%0d/%h",
                         k, instr_valid, pc_out, instr, p, romval(p));
            end
        end
        branch_taken = 1'b0;
        tick();
        checks++;
        if ({instr_valid, pc_out} !== {1'b1, PC_W'(p + 1)}) begin
            failures++;
            $display("FAIL self_loop_exit: valid/pc=%b/%0d want 1/%0d", instr_valid, pc_out, p + 1);
        end
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if ({instr_valid, pc_out, instr} !== {1'b1, PC_W'(k), romval(k)}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wrap_sweep: %0d of 32 steps wrong, want 0", bad);
        end
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 5'd0, romval(0)}) begin
            failures++;
            $display("FAIL wrap_zero: valid/pc/instr=%b/%0d/%h want 1/0/%h",
                     instr_valid, pc_out, instr, romval(0));
        end
        tick();
        checks++;
        if ({instr_valid, pc_out} !== {1'b1, 5'd1}) begin
            failures++;
            $display("FAIL wrap_one: valid/pc=%b/%0d want 1/1", instr_valid, pc_out);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        halt_req = 1'b1;
        branch_taken = 1'b1;
        branch_target = 5'd9;
        tick();
        halt_req = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if ({instr_valid, pc_out, imem_en} !== {1'b0, 5'd4, 1'b0}) begin
            failures++;
            $display("FAIL halt_enter: valid/pc/en=%b/%0d/%b want 0/4/0", instr_valid, pc_out, imem_en);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ({instr_valid, pc_out, imem_en} !== {1'b0, 5'd4, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_hold: %0d of 10 cycles wrong, want 0", bad);
        end
        do_reset();
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 5'd0, romval(0)}) begin
            failures++;
            $display("FAIL halt_restart: valid/pc/instr=%b/%0d/%h want 1/0/%h",
                     instr_valid, pc_out, instr, romval(0));
        end
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        for (int k = 0; k < 7; k++) tick();
        stall = 1'b1;
        tick();
        checks++;
        if (pc_out !== 5'd6) begin
            failures++;
            $display("FAIL rst_stall_pre: pc=%0d want 6", pc_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({instr_valid, pc_out} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL rst_stall_during: valid/pc=%b/%0d want 0/0", instr_valid, pc_out);
        end
        reset = 1'b0;
        stall = 1'b0;
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 5'd0, romval(0)}) begin
            failures++;
            $display("FAIL rst_stall_after: valid/pc/instr=%b/%0d/%h want 1/0/%h",
                     instr_valid, pc_out, instr, romval(0));
        end
        tick();
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 5'd1, romval(1)}) begin
            failures++;
            $display("FAIL rst_stall_next: valid/pc/instr=%b/%0d/%h want 1/1/%h",
                     instr_valid, pc_out, instr, romval(1));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rom[i] = romval(i);
        reset = 1'b1;
        stall = 1'b0;
        halt_req = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        test_reset();
        test_stall();
        test_branch();
        test_self_loop();
        test_wrap();
        test_halt();
        test_reset_in_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
